// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM register and the data memory write port.
// It lane-aligns SB/SH/SW stores and queues them in a FIFO. The oldest store drains
// on idle cycles and on stall cycles. The pipeline stalls on a full buffer, or when a
// load reads a word that still has a store pending in the buffer.
// Optional feature macro: STORE_FWD_EN. It lets a load take the data of the youngest
// matching store when that store wrote the full word.
module store_buffer #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               Funct3,
  input  logic [DM_ADDRESS-1:0]    a,
  input  logic [DATA_W-1:0]        wd,
  output logic                     stall,
  output logic [DM_ADDRESS-1:0]    mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [3:0]               mem_wr,
  output logic                     fwd_valid,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     store_err
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = DM_ADDRESS - 2;

  logic [WAW-1:0]    addr_q [DEPTH];
  logic [WAW-1:0]    addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [3:0]        mask_q [DEPTH];
  logic [3:0]        mask_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              store_err_q, store_err_d;

  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_mask;
  logic              st_bad;
  logic              load_hit, fwd_ok, full, drain, enq;
  logic [PW-1:0]     idx, yng_idx;

  // Lane alignment and legality of the incoming store.
  always_comb begin
    st_data = '0;
    st_mask = '0;
    st_bad  = 1'b0;
    case (Funct3)
      3'b000: begin
        st_data = {4{wd[7:0]}};
        st_mask = 4'b0001 << a[1:0];
      end
      3'b001: begin
        st_data = {2{wd[15:0]}};
        st_mask = a[1] ? 4'b1100 : 4'b0011;
        st_bad  = a[0];
      end
      3'b010: begin
        st_data = wd;
        st_mask = 4'b1111;
        st_bad  = (a[1:0] != 2'b00);
      end
      default: st_bad = 1'b1;
    endcase
  end

  // Load hazard search; walking oldest to youngest leaves the youngest match in yng_idx.
  always_comb begin
    load_hit = 1'b0;
    yng_idx  = rd_ptr_q;
    idx      = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_ptr_q + PW'(i);
      if (MemRead && valid_q[idx] && (addr_q[idx] == a[DM_ADDRESS-1:2])) begin
        load_hit = 1'b1;
        yng_idx  = idx;
      end
    end
  end

  // Stall, forwarding, drain and enqueue decisions plus the memory port.
  always_comb begin
    full = (count_q == CW'(DEPTH));
`ifdef STORE_FWD_EN
    fwd_ok    = load_hit && (mask_q[yng_idx] == 4'b1111);
    fwd_valid = fwd_ok;
    fwd_data  = fwd_ok ? data_q[yng_idx] : '0;
`else
    fwd_ok    = 1'b0;
    fwd_valid = 1'b0;
    fwd_data  = '0;
`endif
    stall     = (MemWrite && full) || (load_hit && !fwd_ok);
    drain     = (count_q != '0) && ((!MemRead && !MemWrite) || stall);
    enq       = MemWrite && !stall && !st_bad;
    mem_waddr = {addr_q[rd_ptr_q], 2'b00};
    mem_wdata = data_q[rd_ptr_q];
    mem_wr    = drain ? mask_q[rd_ptr_q] : 4'b0000;
  end

  // Next-state for FIFO storage, pointers, occupancy and the error pulse.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (drain) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      addr_d[wr_ptr_q]  = a[DM_ADDRESS-1:2];
      data_d[wr_ptr_q]  = st_data;
      mask_d[wr_ptr_q]  = st_mask;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (enq && !drain) begin
      count_d = count_q + 1'b1;
    end else if (!enq && drain) begin
      count_d = count_q - 1'b1;
    end
    // A stalled store is re-presented later, so only a consumed bad store flags an error.
    store_err_d = MemWrite && st_bad && !stall;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      store_err_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      store_err_q <= store_err_d;
    end
  end

  assign count     = count_q;
  assign store_err = store_err_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer. The driver pushes the expected outputs for each
// cycle, computed from a queue-based model. A monitor pops those expectations on the
// falling edge and compares them.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [8:0]  a = '0;
  logic [31:0] wd = '0;
  logic        stall, fwd_valid, store_err;
  logic [8:0]  mem_waddr;
  logic [31:0] mem_wdata, fwd_data;
  logic [3:0]  mem_wr;
  logic [2:0]  count;

  store_buffer #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .a(a), .wd(wd), .stall(stall), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .fwd_valid(fwd_valid), .fwd_data(fwd_data), .count(count),
    .store_err(store_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        drn;
    logic [3:0]  mem_wr;
    logic [8:0]  waddr;
    logic [31:0] wdata;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic [2:0]  count;
    logic        err;
  } exp_t;

  ent_t sb_q[$];
  exp_t exp_q[$];
  logic err_m = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // One pipeline cycle: apply inputs, predict the outputs, then advance the model.
  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [8:0] ad, input logic [31:0] d);
    exp_t e;
    ent_t n;
    logic err, hit, fwd, stl, drn;
    int   y;
    @(posedge clk);
    #1;
    MemRead = mr; MemWrite = mw; Funct3 = f3; a = ad; wd = d;
    err = 1'b0; n.waddr = ad[8:2]; n.mask = '0; n.data = '0;
    case (f3)
      3'd0: begin n.mask = 4'(1 << ad[1:0]); n.data = {24'b0, d[7:0]} * 32'h01010101; end
      3'd1: begin err = ad[0]; n.mask = ad[1] ? 4'hC : 4'h3;
                  n.data = {16'b0, d[15:0]} * 32'h00010001; end
      3'd2: begin err = (ad[1:0] != 2'b00); n.mask = 4'hF; n.data = d; end
      default: err = 1'b1;
    endcase
    hit = 1'b0; y = -1;
    if (mr) for (int i = 0; i < sb_q.size(); i++)
      if (sb_q[i].waddr == ad[8:2]) begin hit = 1'b1; y = i; end
    fwd = 1'b0;
`ifdef STORE_FWD_EN
    if (hit && sb_q[y].mask == 4'hF) fwd = 1'b1;
`endif
    stl = (mw && sb_q.size() == DEPTH) || (hit && !fwd);
    drn = (sb_q.size() != 0) && ((!mr && !mw) || stl);
    e.stall     = stl;
    e.drn       = drn;
    e.mem_wr    = drn ? sb_q[0].mask : 4'h0;
    e.waddr     = drn ? {sb_q[0].waddr, 2'b00} : 9'h0;
    e.wdata     = drn ? sb_q[0].data : 32'h0;
    e.fwd_valid = fwd;
    e.fwd_data  = fwd ? sb_q[y].data : 32'h0;
    e.count     = 3'(sb_q.size());
    e.err       = err_m;
    exp_q.push_back(e);
    if (drn) void'(sb_q.pop_front());
    if (mw && !stl && !err) sb_q.push_back(n);
    err_m = mw && err && !stl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 9'h0, 32'h0);
  endtask

  // Monitor: compares the DUT against each queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cyc++;
      chk("stall", 32'(stall), 32'(e.stall));
      chk("mem_wr", 32'(mem_wr), 32'(e.mem_wr));
      if (e.drn) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(e.waddr));
        chk("mem_wdata", mem_wdata, e.wdata);
      end
      chk("fwd_valid", 32'(fwd_valid), 32'(e.fwd_valid));
      chk("fwd_data", fwd_data, e.fwd_data);
      chk("count", 32'(count), 32'(e.count));
      chk("store_err", 32'(store_err), 32'(e.err));
    end
  end

  initial begin
    logic mr, mw;
    logic [2:0] f3;
    int r;
    // Reset values with reset held.
    #3;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'h0);
    chk("rst_fwd_data", fwd_data, 32'h0);
    chk("rst_store_err", 32'(store_err), 32'h0);
    @(posedge clk); #1; reset = 1'b0;

    // SB to a byte lane, then drain.
    drive(1'b0, 1'b1, 3'd0, 9'h005, 32'h000000AB);
    idle(2);
    // Misaligned SH.
    drive(1'b0, 1'b1, 3'd1, 9'h003, 32'h0000BEEF);
    idle(2);
    // Fill the buffer; the fifth store stalls once and is re-presented.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 3'd2, 9'(i * 4), 32'h1000_0000 + i);
    drive(1'b0, 1'b1, 3'd2, 9'h010, 32'h1000_0004);
    idle(5);
    // Full-word load hit.
    drive(1'b0, 1'b1, 3'd2, 9'h010, 32'h12345678);
    drive(1'b1, 1'b0, 3'd2, 9'h010, 32'h0);
    drive(1'b1, 1'b0, 3'd2, 9'h010, 32'h0);
    idle(2);
    // Partial-mask load hit.
    drive(1'b0, 1'b1, 3'd0, 9'h011, 32'h000000CD);
    drive(1'b1, 1'b0, 3'd2, 9'h010, 32'h0);
    drive(1'b1, 1'b0, 3'd2, 9'h010, 32'h0);
    idle(2);

    // Randomized traffic over a small address window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      mr = (r >= 40 && r < 65);
      mw = (r < 40);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      drive(mr, mw, f3, 9'($urandom_range(0, 31)), $urandom);
    end
    idle(6);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    // Reset while a drain is in progress.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'd2, 9'(8 * i), 32'hCAFE_0000 + i);
    drive(1'b0, 1'b0, 3'd0, 9'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("pre_rst_mem_wr", 32'(mem_wr), 32'hF);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_mem_wr", 32'(mem_wr), 32'h0);
      chk("post_rst_count", 32'(count), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
